regression_sample_sequencer: RTL and testbench

//  Parametrised sample buffer and sequencer for the linear-regression engine.

---
 rtl/regression_sample_sequencer.sv | 196 +++++++++++++++++++
 tb/tb_regression_sample_sequencer.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regression_sample_sequencer.sv
// Sample buffer and replay sequencer for the linear-regression engine.
// Loads up to DEPTH (x,y) samples over a valid/ready stream, then replays
// them as repeated coefficient passes followed by a single error pass.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | no job; waiting for start
// LOAD   | accepting input samples into storage
// COEF   | replaying samples for a coefficient pass (out_mode=0)
// WAIT   | pass finished; waiting for mean_ready / all_ready verdict
// ERR    | replaying samples for the final error pass (out_mode=1)
// DONE   | one-cycle completion pulse, then back to IDLE
module regression_sample_sequencer #(
  parameter int DATA_W     = 20,
  parameter int DEPTH      = 150,
  parameter int ADDR_W     = 8,
  parameter int MAX_PASSES = 64,
  parameter int PASS_W     = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W:0]   n_samples,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_x,
  input  logic [DATA_W-1:0] in_y,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_x,
  output logic [DATA_W-1:0] out_y,
  output logic              out_last,
  output logic              out_mode,
  input  logic              out_ready,
  input  logic              mean_ready,
  input  logic              all_ready,
  output logic              busy,
  output logic              done,
  output logic              timeout,
  output logic [PASS_W-1:0] pass_cnt
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_COEF = 3'd2,
    S_WAIT = 3'd3,
    S_ERR  = 3'd4,
    S_DONE = 3'd5
  } state_t;

  localparam logic [ADDR_W:0]   DEPTH_N = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   ONE_N   = (ADDR_W+1)'(1);
  localparam logic [PASS_W-1:0] MAX_P   = PASS_W'(MAX_PASSES);

  state_t state, state_nxt;

  logic [ADDR_W:0]     n_q;
  logic [ADDR_W:0]     n_last;
  logic [ADDR_W:0]     n_lat;
  logic [ADDR_W-1:0]   wr_idx;
  logic [ADDR_W-1:0]   rd_idx;
  logic [PASS_W-1:0]   pass_q;
  logic                timeout_q;
  logic                wr_at_last;
  logic                rd_at_last;
  logic                can_repeat;
  logic [2*DATA_W-1:0] rd_word;

  // Sample storage; deliberately left uninitialised across reset and jobs.
  logic [2*DATA_W-1:0] mem [DEPTH];

  // A count of zero or anything beyond the buffer means "use the whole buffer".
  assign n_lat      = (n_samples == '0 || n_samples > DEPTH_N) ? DEPTH_N : n_samples;
  assign n_last     = n_q - ONE_N;
  assign wr_at_last = ({1'b0, wr_idx} == n_last);
  assign rd_at_last = ({1'b0, rd_idx} == n_last);
  assign can_repeat = (pass_q < MAX_P);
  assign rd_word    = mem[rd_idx];

  assign timeout  = timeout_q;
  assign pass_cnt = pass_q;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode; abort overrides every other transition.
  always_comb begin
    state_nxt = state;
    if (abort) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE: if (start) state_nxt = S_LOAD;
        S_LOAD: if (in_valid && wr_at_last) state_nxt = S_COEF;
        S_COEF: if (out_ready && rd_at_last) state_nxt = S_WAIT;
        S_WAIT: begin
          if (all_ready) begin
            state_nxt = S_ERR;
          end else if (mean_ready) begin
            state_nxt = can_repeat ? S_COEF : S_ERR;
          end
        end
        S_ERR:  if (out_ready && rd_at_last) state_nxt = S_DONE;
        S_DONE: state_nxt = S_IDLE;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // Output decode; replay data is masked to zero outside a valid beat.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_mode  = 1'b0;
    done      = 1'b0;
    busy      = (state != S_IDLE);
    case (state)
      S_LOAD: in_ready = 1'b1;
      S_COEF: out_valid = 1'b1;
      S_ERR: begin
        out_valid = 1'b1;
        out_mode  = 1'b1;
      end
      S_DONE: done = 1'b1;
      default: ;
    endcase
    out_x    = out_valid ? rd_word[2*DATA_W-1:DATA_W] : '0;
    out_y    = out_valid ? rd_word[DATA_W-1:0] : '0;
    out_last = out_valid && rd_at_last;
  end

  // Job bookkeeping: sample count, write/read indices, pass counter, timeout flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      n_q       <= '0;
      wr_idx    <= '0;
      rd_idx    <= '0;
      pass_q    <= '0;
      timeout_q <= 1'b0;
    end else if (!abort) begin
      case (state)
        S_IDLE: begin
          if (start) begin
            n_q       <= n_lat;
            wr_idx    <= '0;
            pass_q    <= '0;
            timeout_q <= 1'b0;
          end
        end
        S_LOAD: begin
          if (in_valid) begin
            wr_idx <= wr_idx + ADDR_W'(1);
            if (wr_at_last) begin
              rd_idx <= '0;
              pass_q <= pass_q + PASS_W'(1);
            end
          end
        end
        S_COEF, S_ERR: begin
          // The index parks on the last sample; the next pass restarts it.
          if (out_ready && !rd_at_last) begin
            rd_idx <= rd_idx + ADDR_W'(1);
          end
        end
        S_WAIT: begin
          if (all_ready) begin
            rd_idx <= '0;
          end else if (mean_ready) begin
            rd_idx <= '0;
            if (can_repeat) begin
              pass_q <= pass_q + PASS_W'(1);
            end else begin
              timeout_q <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Sample capture during LOAD; an aborted cycle writes nothing.
  always_ff @(posedge clk) begin
    if (state == S_LOAD && in_valid && !abort) begin
      mem[wr_idx] <= {in_x, in_y};
    end
  end

endmodule

// File: tb/tb_regression_sample_sequencer.sv
// Bench for regression_sample_sequencer: a job-level model (flags, pass
// position, stored-sample arrays) is compared against two DUTs every cycle,
// one with the default pass limit and one with a limit of 2.
module tb_regression_sample_sequencer;

  localparam int DW    = 20;
  localparam int DEPTH = 150;
  localparam int AW    = 8;
  localparam int PW    = 7;
  localparam int MAXP [2] = '{64, 2};

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [1:0]    start = '0;
  logic          abort = 1'b0;
  logic [AW:0]   n_samples = '0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_x = '0;
  logic [DW-1:0] in_y = '0;
  logic          out_ready = 1'b0;
  logic          mean_ready = 1'b0;
  logic          all_ready = 1'b0;

  logic          in_ready [2];
  logic          out_valid [2];
  logic [DW-1:0] out_x [2];
  logic [DW-1:0] out_y [2];
  logic          out_last [2];
  logic          out_mode [2];
  logic          busy [2];
  logic          done [2];
  logic          timeout [2];
  logic [PW-1:0] pass_cnt [2];

  regression_sample_sequencer dut0 (
    .clk(clk), .rst(rst), .start(start[0]), .abort(abort), .n_samples(n_samples),
    .in_valid(in_valid), .in_x(in_x), .in_y(in_y), .in_ready(in_ready[0]),
    .out_valid(out_valid[0]), .out_x(out_x[0]), .out_y(out_y[0]), .out_last(out_last[0]),
    .out_mode(out_mode[0]), .out_ready(out_ready), .mean_ready(mean_ready),
    .all_ready(all_ready), .busy(busy[0]), .done(done[0]), .timeout(timeout[0]),
    .pass_cnt(pass_cnt[0])
  );

  regression_sample_sequencer #(.MAX_PASSES(2)) dut1 (
    .clk(clk), .rst(rst), .start(start[1]), .abort(abort), .n_samples(n_samples),
    .in_valid(in_valid), .in_x(in_x), .in_y(in_y), .in_ready(in_ready[1]),
    .out_valid(out_valid[1]), .out_x(out_x[1]), .out_y(out_y[1]), .out_last(out_last[1]),
    .out_mode(out_mode[1]), .out_ready(out_ready), .mean_ready(mean_ready),
    .all_ready(all_ready), .busy(busy[1]), .done(done[1]), .timeout(timeout[1]),
    .pass_cnt(pass_cnt[1])
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- job-level model ----------------
  bit            m_load [2], m_replay [2], m_wait [2], m_done [2], m_err [2], m_tmo [2];
  int            m_n [2], m_wr [2], m_pos [2], m_pass [2];
  logic [DW-1:0] m_x [2][DEPTH];
  logic [DW-1:0] m_y [2][DEPTH];

  task automatic m_reset(input int m);
    m_load[m] = 0; m_replay[m] = 0; m_wait[m] = 0; m_done[m] = 0; m_err[m] = 0;
    m_tmo[m] = 0; m_pass[m] = 0; m_wr[m] = 0; m_pos[m] = 0;
  endtask

  task automatic m_new_pass(input int m, input bit err);
    m_replay[m] = 1; m_err[m] = err; m_pos[m] = 0;
  endtask

  // Advances the model by one clock using the inputs the next edge will sample.
  task automatic m_advance(input int m);
    if (abort) begin
      m_load[m] = 0; m_replay[m] = 0; m_wait[m] = 0; m_done[m] = 0;
    end else if (m_done[m]) begin
      m_done[m] = 0;
    end else if (m_load[m]) begin
      if (in_valid) begin
        if (m_wr[m] < DEPTH) begin
          m_x[m][m_wr[m]] = in_x;
          m_y[m][m_wr[m]] = in_y;
        end
        m_wr[m]++;
        if (m_wr[m] == m_n[m]) begin
          m_load[m] = 0;
          m_new_pass(m, 0);
          m_pass[m]++;
        end
      end
    end else if (m_replay[m]) begin
      if (out_ready) begin
        if (m_pos[m] == m_n[m] - 1) begin
          m_replay[m] = 0;
          if (m_err[m]) m_done[m] = 1;
          else          m_wait[m] = 1;
        end else begin
          m_pos[m]++;
        end
      end
    end else if (m_wait[m]) begin
      if (all_ready) begin
        m_wait[m] = 0;
        m_new_pass(m, 1);
      end else if (mean_ready) begin
        m_wait[m] = 0;
        if (m_pass[m] < MAXP[m]) begin
          m_new_pass(m, 0);
          m_pass[m]++;
        end else begin
          m_new_pass(m, 1);
          m_tmo[m] = 1;
        end
      end
    end else if (start[m]) begin
      m_n[m]    = (n_samples == 0 || int'(n_samples) > DEPTH) ? DEPTH : int'(n_samples);
      m_tmo[m]  = 0;
      m_pass[m] = 0;
      m_wr[m]   = 0;
      m_load[m] = 1;
    end
  endtask

  task automatic m_compare(input int m);
    chk($sformatf("d%0d_busy", m), busy[m], m_load[m] | m_replay[m] | m_wait[m] | m_done[m]);
    chk($sformatf("d%0d_in_ready", m), in_ready[m], m_load[m]);
    chk($sformatf("d%0d_out_valid", m), out_valid[m], m_replay[m]);
    chk($sformatf("d%0d_out_mode", m), out_mode[m], m_replay[m] & m_err[m]);
    chk($sformatf("d%0d_done", m), done[m], m_done[m]);
    chk($sformatf("d%0d_timeout", m), timeout[m], m_tmo[m]);
    chk($sformatf("d%0d_pass_cnt", m), pass_cnt[m], m_pass[m]);
    if (m_replay[m]) begin
      chk($sformatf("d%0d_out_x", m), out_x[m], m_x[m][m_pos[m]]);
      chk($sformatf("d%0d_out_y", m), out_y[m], m_y[m][m_pos[m]]);
      chk($sformatf("d%0d_out_last", m), out_last[m], m_pos[m] == m_n[m] - 1);
    end else begin
      chk($sformatf("d%0d_out_last_idle", m), out_last[m], 0);
    end
  endtask

  // Inputs only change just after rising edges, so at the falling edge they
  // equal what the next rising edge samples.
  initial begin
    m_reset(0);
    m_reset(1);
    forever begin
      @(negedge clk);
      for (int m = 0; m < 2; m++) begin
        if (rst) m_reset(m);
        m_compare(m);
        if (!rst) m_advance(m);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic begin_job(input int m, input int ns);
    n_samples = (AW+1)'(ns);
    start[m]  = 1'b1;
    step();
    start[m]  = 1'b0;
  endtask

  task automatic load(input int cnt, input int base);
    for (int i = 0; i < cnt; i++) begin
      in_valid = 1'b1;
      in_x     = DW'(base + i);
      in_y     = DW'(base + i + 'h40000);
      step();
    end
    in_valid = 1'b0;
  endtask

  task automatic run_beats(input int cnt);
    out_ready = 1'b1;
    repeat (cnt) step();
    out_ready = 1'b0;
  endtask

  task automatic pulse_mean();
    mean_ready = 1'b1; step(); mean_ready = 1'b0;
  endtask

  task automatic pulse_all();
    all_ready = 1'b1; step(); all_ready = 1'b0;
  endtask

  logic [DW-1:0] cap_x [4];
  logic          cap_l [4];
  bit            pat [6] = '{1, 0, 0, 1, 1, 1};
  int            k;
  int            nacc;

  initial begin
    repeat (3) step();
    chk("rst_busy", busy[0], 0);
    chk("rst_out_valid", out_valid[0], 0);
    chk("rst_pass_cnt", pass_cnt[0], 0);
    chk("rst_out_x", out_x[0], 0);
    rst = 1'b0;
    step();

    // Job A: n=4, stalls during the first pass, two repeats, then error pass.
    begin_job(0, 4);
    chk("A_load_ready", in_ready[0], 1);
    load(4, 'h100);
    chk("A_ready_low_after_4", in_ready[0], 0);
    chk("A_first_beat_latency", out_valid[0], 1);
    chk("A_first_x", out_x[0], 'h100);
    k = 0;
    for (int i = 0; i < 6; i++) begin
      out_ready = pat[i];
      if (i == 1 || i == 2) chk("A_stall_x", out_x[0], 'h101);
      if (pat[i] && out_valid[0] && k < 4) begin
        cap_x[k] = out_x[0];
        cap_l[k] = out_last[0];
        k++;
      end
      step();
    end
    out_ready = 1'b0;
    chk("A_beats", k, 4);
    for (int i = 0; i < 4; i++) chk("A_seq_x", cap_x[i], 'h100 + i);
    chk("A_last_beat3", cap_l[2], 0);
    chk("A_last_beat4", cap_l[3], 1);
    chk("A_wait_no_valid", out_valid[0], 0);
    pulse_mean();
    chk("A_pass2", pass_cnt[0], 2);
    run_beats(4);
    pulse_mean();
    chk("A_pass3", pass_cnt[0], 3);
    run_beats(4);
    pulse_all();
    chk("A_err_mode", out_mode[0], 1);
    chk("A_err_pass_cnt", pass_cnt[0], 3);
    run_beats(4);
    chk("A_done", done[0], 1);
    step();
    chk("A_done_once", done[0], 0);
    chk("A_idle", busy[0], 0);

    // Job B: mean_ready and all_ready together -> error pass, count unchanged.
    begin_job(0, 2);
    load(2, 'h200);
    run_beats(2);
    mean_ready = 1'b1; all_ready = 1'b1;
    step();
    mean_ready = 1'b0; all_ready = 1'b0;
    chk("B_both_err", out_mode[0], 1);
    chk("B_pass_cnt", pass_cnt[0], 1);
    run_beats(2);
    step();

    // Job C: pass limit of 2 forces the error pass with timeout.
    begin_job(1, 3);
    load(3, 'h400);
    run_beats(3);
    pulse_mean();
    chk("C_pass2", pass_cnt[1], 2);
    run_beats(3);
    pulse_mean();
    chk("C_forced_err", out_mode[1], 1);
    chk("C_timeout", timeout[1], 1);
    chk("C_pass_cnt", pass_cnt[1], 2);
    run_beats(3);
    step();
    chk("C_timeout_sticky", timeout[1], 1);
    begin_job(1, 3);
    chk("C_timeout_cleared", timeout[1], 0);
    abort = 1'b1; step(); abort = 1'b0;
    chk("C_abort_idle", busy[1], 0);

    // Job D: abort after 2 of 4 loads, then a fresh job reloads from index 0.
    begin_job(0, 4);
    load(2, 'h500);
    abort = 1'b1; step(); abort = 1'b0;
    chk("D_ready_after_abort", in_ready[0], 0);
    chk("D_no_done", done[0], 0);
    begin_job(0, 4);
    load(4, 'h600);
    chk("D_reload_x0", out_x[0], 'h600);
    run_beats(4);
    pulse_all();
    run_beats(4);
    step();

    // Job E: single-sample job; every pass is one last beat.
    begin_job(0, 1);
    load(1, 'h700);
    chk("E_last_coef1", out_last[0], 1);
    run_beats(1);
    pulse_mean();
    chk("E_last_coef2", out_last[0], 1);
    run_beats(1);
    pulse_all();
    chk("E_last_err", out_last[0], 1);
    run_beats(1);
    step();

    // Job F: n_samples=0 clamps to DEPTH; reset pulse in the middle of COEF.
    begin_job(0, 0);
    nacc = 0;
    for (int i = 0; i < 200 && in_ready[0]; i++) begin
      in_valid = 1'b1;
      in_x = DW'('h1000 + i);
      in_y = DW'('h2000 + i);
      step();
      nacc++;
    end
    in_valid = 1'b0;
    chk("F_clamp_count", nacc, DEPTH);
    chk("F_replay_start", out_x[0], 'h1000);
    run_beats(2);
    rst = 1'b1;
    #1;
    chk("F_rst_valid", out_valid[0], 0);
    chk("F_rst_busy", busy[0], 0);
    chk("F_rst_x", out_x[0], 0);
    chk("F_rst_pass", pass_cnt[0], 0);
    chk("F_rst_mode", out_mode[0], 0);
    step();
    rst = 1'b0;
    repeat (2) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
